pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge.
REQ-002 rst  in  1  reset; asynchronous, active-high.
REQ-003 id_valid  in  1  decode slot holds an instruction.
REQ-004 id_instr  in  16  decode instruction; rm=[8:6], rn=[5:3], rd=[2:0], type=[15:14].
REQ-005 ex_valid  in  1  execute stage holds an instruction.
REQ-006 ex_instr  in  16  instruction currently in execute.
REQ-007 ex_done  in  1  execute result final (A/R type).
REQ-008 branch_flush  in  1  kill decode-slot instruction this cycle.
REQ-009 mem_ready  in  1  memory completed the load request.
REQ-010 stall  out  1  hold fetch/decode; no issue this cycle.
REQ-011 issue  out  1  decode instruction advances to execute this cycle.
REQ-012 mem_req  out  1  load request to memory, level-held.
REQ-013 wb_en  out  1  register write strobe, one-cycle pulse.
REQ-014 wb_rd  out  3  write-back destination register.
REQ-015 fwd_rn_sel, fwd_rm_sel  out  2 each  operand source: 00 regfile, 01 execute result, 10 write-back value.
REQ-016 stall_cycles  out  8  saturating count of stalled cycles.

Function
REQ-017 A "writer" is type A_TYPE, R_TYPE, or opcode [15:12]=4'b1000 (LOAD).
REQ-018 Scoreboard: 8-bit pending mask; bit rd set on issue of a writer, cleared on wb_en for wb_rd; set and clear of the same bit in one cycle -> set wins.
REQ-019 issue = id_valid & ~stall & ~branch_flush (combinational).
REQ-020 FSM states RUN, MEM_WAIT; RUN->MEM_WAIT when ex_valid & ex_instr is LOAD; MEM_WAIT->RUN on cycle mem_ready=1.
REQ-021 mem_req=1 exactly while state=MEM_WAIT; mem_ready outside MEM_WAIT ignored.
REQ-022 wb_en/wb_rd registered: pulse one cycle after ex_done for A/R in execute, or one cycle after mem_ready in MEM_WAIT.
REQ-023 stall = id_valid & (state==MEM_WAIT | raw_hazard); raw_hazard per REQ-030/031.
REQ-024 branch_flush does not clear pending bits nor abort MEM_WAIT.
REQ-025 stall_cycles increments each cycle stall=1; saturates at 255; no wrap.
REQ-026 Latency: issue -> execute result one cycle later -> wb_en one cycle after ex_done.

Reset
REQ-027 On rst: state=RUN, pending=0, stall_cycles=0, wb_en=0, wb_rd=0, fwd selects=00.
REQ-028 rst mid-MEM_WAIT drops mem_req same cycle (async); outstanding load discarded.
REQ-029 Combinational outputs (stall, issue, mem_req) evaluate to 0 while rst held.

Configuration
REQ-030 Macro HAZARD_FORWARD_EN defined: raw_hazard only when an id source equals rd of a LOAD in execute/MEM_WAIT (load-use); other matches forwarded via fwd_*_sel (execute rd match -> 01, else write-back match -> 10; execute wins).
REQ-031 HAZARD_FORWARD_EN undefined: raw_hazard = pending[rn] | pending[rm]; fwd_*_sel tied to 00.

Structure
REQ-032 Shared package tsp16_pkg holds A_TYPE, R_TYPE, OP_LOAD, state enum, fwd-select enum.
REQ-033 Sub-module hazard_scoreboard holds pending mask and set/clear logic.

Verification
REQ-034 Reset: assert rst with id_valid=1 -> stall=0, issue=0, pending=0, stall_cycles=0.
REQ-035 No forwarding: issue ADD rd=r3, next instr reads rn=r3 -> stall=1 until cycle after wb_en (wb_rd=3), then issue=1.
REQ-036 HAZARD_FORWARD_EN: same sequence -> no stall, fwd_rn_sel=01 on the dependent cycle.
REQ-037 LOAD rd=r2 reaches execute, mem_ready after 3 cycles -> mem_req high 3 cycles, stall high, wb_en pulse wb_rd=2 next cycle.
REQ-038 Set/clear collision: wb_en for r5 same cycle new writer to r5 issues -> pending[5]=1 afterwards.
REQ-039 Hold stall 300 cycles -> stall_cycles=255, no wrap; branch_flush during stall -> issue=0, pending unchanged.

Source files
------------

// File: rtl/tsp16_pkg.sv
// Shared encodings for the TSP16 decode/execute hazard controller: instruction type codes,
// controller states and operand-forwarding selects.
package tsp16_pkg;

  localparam logic [1:0] A_TYPE  = 2'b00;
  localparam logic [1:0] R_TYPE  = 2'b01;
  localparam logic [3:0] OP_LOAD = 4'b1000;

  typedef enum logic [0:0] {
    StRun,
    StMemWait
  } state_e;

  typedef enum logic [1:0] {
    FwdRegfile = 2'b00,
    FwdExec    = 2'b01,
    FwdWb      = 2'b10
  } fwd_sel_e;

  function automatic logic is_ar(input logic [1:0] ty);
    return (ty == A_TYPE) || (ty == R_TYPE);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return op == OP_LOAD;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write mask: one bit per architectural register, set on issue of a writer and
// cleared on its write-back strobe.
module hazard_scoreboard
  import tsp16_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en_i,
  input  logic [2:0] set_idx_i,
  input  logic       clr_en_i,
  input  logic [2:0] clr_idx_i,
  output logic [7:0] pending_o
);

  logic [7:0] pending_d, pending_q;

  // Set is applied after clear so a same-cycle collision leaves the bit pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
    if (set_en_i) pending_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: RAW stall/issue, load wait FSM, write-back strobe and
// saturating stall counter. Define HAZARD_FORWARD_EN to stall only on load-use and forward.
module pipeline_hazard_ctrl
  import tsp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  input  logic        ex_valid,
  input  logic [15:0] ex_instr,
  input  logic        ex_done,
  input  logic        branch_flush,
  input  logic        mem_ready,
  output logic        stall,
  output logic        issue,
  output logic        mem_req,
  output logic        wb_en,
  output logic [2:0]  wb_rd,
  output logic [1:0]  fwd_rn_sel,
  output logic [1:0]  fwd_rm_sel,
  output logic [7:0]  stall_cycles
);

  state_e     state_d, state_q;
  logic [2:0] load_rd_d, load_rd_q;
  logic       wb_en_d, wb_en_q;
  logic [2:0] wb_rd_d, wb_rd_q;
  logic [7:0] stall_cnt_d, stall_cnt_q;
  logic [7:0] pending;
  logic       raw_hazard;

  logic [2:0] id_rn, id_rm, id_rd, ex_rd;
  logic       ex_is_load, ex_is_ar, id_is_writer, in_mem_wait;

  assign id_rn        = id_instr[5:3];
  assign id_rm        = id_instr[8:6];
  assign id_rd        = id_instr[2:0];
  assign ex_rd        = ex_instr[2:0];
  assign ex_is_load   = ex_valid & is_load(ex_instr[15:12]);
  assign ex_is_ar     = ex_valid & is_ar(ex_instr[15:14]);
  assign id_is_writer = is_ar(id_instr[15:14]) | is_load(id_instr[15:12]);
  assign in_mem_wait  = (state_q == StMemWait);

`ifdef HAZARD_FORWARD_EN
  fwd_sel_e rn_sel, rm_sel;
  logic     ld_use_rn, ld_use_rm;
  logic     unused_bits;

  assign ld_use_rn = (ex_is_load && ex_rd == id_rn) || (in_mem_wait && load_rd_q == id_rn);
  assign ld_use_rm = (ex_is_load && ex_rd == id_rm) || (in_mem_wait && load_rd_q == id_rm);
  assign raw_hazard = ld_use_rn | ld_use_rm;

  // Execute-stage result is younger than the write-back value, so it takes priority.
  always_comb begin
    rn_sel = FwdRegfile;
    rm_sel = FwdRegfile;
    if (!rst) begin
      if (ex_is_ar && ex_rd == id_rn)         rn_sel = FwdExec;
      else if (wb_en_q && wb_rd_q == id_rn)   rn_sel = FwdWb;
      if (ex_is_ar && ex_rd == id_rm)         rm_sel = FwdExec;
      else if (wb_en_q && wb_rd_q == id_rm)   rm_sel = FwdWb;
    end
  end

  assign fwd_rn_sel  = rn_sel;
  assign fwd_rm_sel  = rm_sel;
  assign unused_bits = ^{id_instr[11:9], ex_instr[11:3], pending};
`else
  logic unused_bits;

  assign raw_hazard  = pending[id_rn] | pending[id_rm];
  assign fwd_rn_sel  = FwdRegfile;
  assign fwd_rm_sel  = FwdRegfile;
  assign unused_bits = ^{id_instr[11:9], ex_instr[11:3]};
`endif

  // Gated by rst so these read 0 for the whole reset window, not just after the edge.
  assign stall   = ~rst & id_valid & (in_mem_wait | raw_hazard);
  assign issue   = ~rst & id_valid & ~stall & ~branch_flush;
  assign mem_req = ~rst & in_mem_wait;

  always_comb begin
    state_d   = state_q;
    load_rd_d = load_rd_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    case (state_q)
      StRun: begin
        if (ex_is_ar && ex_done) begin
          wb_en_d = 1'b1;
          wb_rd_d = ex_rd;
        end
        if (ex_is_load) begin
          state_d   = StMemWait;
          load_rd_d = ex_rd;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d = StRun;
          wb_en_d = 1'b1;
          wb_rd_d = load_rd_q;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign stall_cnt_d = (stall && stall_cnt_q != 8'hFF) ? stall_cnt_q + 8'd1 : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      load_rd_q   <= '0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      load_rd_q   <= load_rd_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  hazard_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (issue & id_is_writer),
    .set_idx_i (id_rd),
    .clr_en_i  (wb_en_q),
    .clr_idx_i (wb_rd_q),
    .pending_o (pending)
  );

  assign wb_en        = wb_en_q;
  assign wb_rd        = wb_rd_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; expectations follow HAZARD_FORWARD_EN.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_instr;
  logic        ex_valid;
  logic [15:0] ex_instr;
  logic        ex_done;
  logic        branch_flush;
  logic        mem_ready;
  logic        stall, issue, mem_req, wb_en;
  logic [2:0]  wb_rd;
  logic [1:0]  fwd_rn_sel, fwd_rm_sel;
  logic [7:0]  stall_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .ex_valid     (ex_valid),
    .ex_instr     (ex_instr),
    .ex_done      (ex_done),
    .branch_flush (branch_flush),
    .mem_ready    (mem_ready),
    .stall        (stall),
    .issue        (issue),
    .mem_req      (mem_req),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .fwd_rn_sel   (fwd_rn_sel),
    .fwd_rm_sel   (fwd_rm_sel),
    .stall_cycles (stall_cycles)
  );

  function automatic logic [15:0] mk(input logic [1:0] ty, input logic [2:0] rm,
                                     input logic [2:0] rn, input logic [2:0] rd);
    return {ty, 5'b00000, rm, rn, rd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b1; id_instr = mk(2'b00, 3'd1, 3'd2, 3'd3);
    ex_valid = 1'b0; ex_instr = '0; ex_done = 1'b0; branch_flush = 1'b0; mem_ready = 1'b0;
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_issue", issue, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_pending", dut.u_scoreboard.pending_o, 0);
    chk("reset_stall_cycles", stall_cycles, 0);
    chk("reset_wb_en", wb_en, 0);
    chk("reset_wb_rd", wb_rd, 0);
    chk("reset_fwd", {fwd_rn_sel, fwd_rm_sel}, 0);
    tick(); tick();
    rst = 1'b0; id_valid = 1'b0;

    // mem_ready in RUN must be ignored
    mem_ready = 1'b1; #1;
    chk("ign_mem_req", mem_req, 0);
    tick();
    chk("ign_wb_en", wb_en, 0);
    mem_ready = 1'b0;

    // ADD r3 then dependent SUB reading rn=r3
    id_valid = 1'b1; id_instr = mk(2'b00, 3'd2, 3'd1, 3'd3); #1;
    chk("add_issue", issue, 1);
    tick();
    chk("add_pending", dut.u_scoreboard.pending_o, 8'h08);
    id_instr = mk(2'b01, 3'd0, 3'd3, 3'd4);
    ex_valid = 1'b1; ex_instr = mk(2'b00, 3'd2, 3'd1, 3'd3); ex_done = 1'b1; #1;
    chk("dep_stall", stall, FWD ? 0 : 1);
    chk("dep_issue", issue, FWD ? 1 : 0);
    chk("dep_fwd_rn", fwd_rn_sel, FWD ? 1 : 0);
    chk("dep_fwd_rm", fwd_rm_sel, 0);
    tick();
    ex_valid = 1'b0; ex_done = 1'b0;
    chk("add_wb_en", wb_en, 1);
    chk("add_wb_rd", wb_rd, 3);
`ifdef HAZARD_FORWARD_EN
    id_valid = 1'b0; #1;
    chk("wb_fwd_rn", fwd_rn_sel, 2);
    chk("wb_pending", dut.u_scoreboard.pending_o, 8'h18);
`else
    #1;
    chk("wb_stall", stall, 1);
    chk("wb_issue", issue, 0);
    chk("wb_pending", dut.u_scoreboard.pending_o, 8'h08);
`endif
    tick();
    chk("add_wb_en_low", wb_en, 0);
`ifndef HAZARD_FORWARD_EN
    chk("clr_pending", dut.u_scoreboard.pending_o, 0);
    #1;
    chk("dep_release_stall", stall, 0);
    chk("dep_release_issue", issue, 1);
    tick();
`endif
    chk("sub_pending", dut.u_scoreboard.pending_o, 8'h10);
    id_valid = 1'b0;
    ex_valid = 1'b1; ex_instr = mk(2'b01, 3'd0, 3'd3, 3'd4); ex_done = 1'b1;
    tick();
    ex_valid = 1'b0; ex_done = 1'b0;
    chk("sub_wb_rd", {wb_en, wb_rd}, {1'b1, 3'd4});
    tick();
    chk("drain_pending", dut.u_scoreboard.pending_o, 0);
    chk("cnt_after_dep", stall_cycles, FWD ? 0 : 2);

    // LOAD r2 in execute, mem_ready on the third wait cycle
    id_valid = 1'b1; id_instr = mk(2'b11, 3'd0, 3'd2, 3'd0);
    ex_valid = 1'b1; ex_instr = mk(2'b10, 3'd0, 3'd0, 3'd2); #1;
    chk("ld_mem_req0", mem_req, 0);
    chk("ld_use_stall", stall, FWD ? 1 : 0);
    chk("ld_use_issue", issue, FWD ? 0 : 1);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      chk("ld_mem_req", mem_req, 1);
      chk("ld_stall", stall, 1);
      chk("ld_issue", issue, 0);
      tick();
    end
    mem_ready = 1'b0;
    chk("ld_wb", {wb_en, wb_rd}, {1'b1, 3'd2});
    #1;
    chk("ld_mem_req_low", mem_req, 0);
    chk("ld_after_stall", stall, 0);
    chk("ld_after_fwd_rn", fwd_rn_sel, FWD ? 2 : 0);
    tick();
    id_valid = 1'b0;
    chk("ld_wb_pulse", wb_en, 0);
    chk("cnt_after_ld", stall_cycles, FWD ? 4 : 5);

    // Set/clear collision on r5
    id_valid = 1'b1; id_instr = mk(2'b00, 3'd0, 3'd0, 3'd5); #1;
    chk("r5_issue", issue, 1);
    tick();
    chk("r5_pending", dut.u_scoreboard.pending_o, 8'h20);
    id_valid = 1'b0;
    ex_valid = 1'b1; ex_instr = mk(2'b00, 3'd0, 3'd0, 3'd5); ex_done = 1'b1;
    tick();
    ex_valid = 1'b0; ex_done = 1'b0;
    chk("col_wb", {wb_en, wb_rd}, {1'b1, 3'd5});
    id_valid = 1'b1; id_instr = mk(2'b00, 3'd1, 3'd1, 3'd5); #1;
    chk("col_issue", issue, 1);
    tick();
    id_valid = 1'b0;
    chk("col_pending", dut.u_scoreboard.pending_o, 8'h20);

    // Long MEM_WAIT: saturation, branch_flush while stalled
    ex_valid = 1'b1; ex_instr = mk(2'b10, 3'd0, 3'd0, 3'd6);
    tick();
    ex_valid = 1'b0;
    id_valid = 1'b1; id_instr = mk(2'b00, 3'd7, 3'd7, 3'd7);
    repeat (10) tick();
    chk("cnt_mid", stall_cycles, FWD ? 14 : 15);
    branch_flush = 1'b1; #1;
    chk("flush_issue", issue, 0);
    chk("flush_stall", stall, 1);
    tick();
    branch_flush = 1'b0; #1;
    chk("flush_pending", dut.u_scoreboard.pending_o, 8'h20);
    chk("flush_mem_req", mem_req, 1);
    repeat (289) tick();
    chk("cnt_sat", stall_cycles, 255);
    tick();
    chk("cnt_no_wrap", stall_cycles, 255);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; id_valid = 1'b0;
    chk("long_ld_wb", {wb_en, wb_rd}, {1'b1, 3'd6});
    chk("long_pending", dut.u_scoreboard.pending_o, 8'h20);

    // Asynchronous reset in the middle of MEM_WAIT
    ex_valid = 1'b1; ex_instr = mk(2'b10, 3'd0, 3'd0, 3'd1);
    tick();
    ex_valid = 1'b0; id_valid = 1'b1; #1;
    chk("arst_pre_mem_req", mem_req, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_issue", issue, 0);
    chk("arst_cnt", stall_cycles, 0);
    chk("arst_pending", dut.u_scoreboard.pending_o, 0);
    tick();
    rst = 1'b0; id_valid = 1'b0; #1;
    chk("arst_run_mem_req", mem_req, 0);
    chk("arst_wb_en", wb_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
